tmds_link_sequencer: RTL and testbench
======================================

Name: tmds_link_sequencer

Overview:
- Pixel-clock controller that sequences the three TMDS channels feeding the 10:1 serializers of the DVI/HDMI transmitter.
- Runs the video timing counters and handles link start-up: idle, then warm-up frames of control tokens only, then active video.
- During blanking it chooses the 10-bit symbol per channel: a control token. During display it chooses the TMDS encoder output.
- Requests pixels from upstream ahead of time so that encoded symbols arrive in alignment.

Parameters:
H_SYNC, 44, hsync width in pixel clocks
H_BACK, 148, horizontal back porch
H_DISP, 1920, active pixels per line
H_FRONT, 88, horizontal front porch
V_SYNC, 5, vsync width in lines
V_BACK, 36, vertical back porch
V_DISP, 1080, active lines
V_FRONT, 4, vertical front porch
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
WARMUP_FRAMES, 2, full frames of control-only symbols before the first active frame (range 0..15)

Ports:
pixel_clk  in  1  pixel clock (serializer clock is 5x this)
rst_n  in  1  asynchronous active-low reset
link_en  in  1  request link activity; level-sensitive
enc_ch0  in  10  encoded blue symbol; valid exactly 1 cycle after pix_req
enc_ch1  in  10  encoded green symbol; same timing as enc_ch0
enc_ch2  in  10  encoded red symbol; same timing as enc_ch0
pix_req  out  1  pixel request to upstream and encoders
pix_x  out  12  active-area column of the requested pixel; valid with pix_req
pix_y  out  12  active-area row of the requested pixel; valid with pix_req
sym_ch0  out  10  symbol to the serializer for channel 0
sym_ch1  out  10  symbol to the serializer for channel 1
sym_ch2  out  10  symbol to the serializer for channel 2
hsync  out  1  aligned with sym_ch*
vsync  out  1  aligned with sym_ch*
de  out  1  aligned with sym_ch*
link_up  out  1  high while in ACTIVE

Behaviour:
- Decided: single clock pixel_clk; reset rst_n is asynchronous and active-low.
- Derived totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.

Counters:
- h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Both counters are held at 0 in IDLE.
- Frame end (FE) is h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.

Regions:
- Sync active when h_cnt<H_SYNC (hsync) or v_cnt<V_SYNC (vsync). Active level is HS_POL / VS_POL.
- Display when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt is in the equivalent V window.

FSM (IDLE, WARMUP, ACTIVE):
- IDLE: when link_en=1, go to WARMUP on the next edge. Load warm_cnt = WARMUP_FRAMES.
- WARMUP: at each FE, decrement warm_cnt. At the FE where warm_cnt==0, go to ACTIVE. With WARMUP_FRAMES=0, this happens at the first FE, so one control-only frame always precedes video.
- ACTIVE: at FE with link_en=0, go to IDLE. A link_en drop mid-frame completes the frame; re-assertion before FE keeps the FSM in ACTIVE.
- WARMUP with link_en=0 at any cycle: go to IDLE immediately.

Pipeline, with counters at cycle T:
- pix_req, pix_x, pix_y are registered and valid at T+1.
- pix_req = display region && state==ACTIVE.
- pix_x = h_cnt-(H_SYNC+H_BACK); pix_y = v_cnt-(V_SYNC+V_BACK).
- Encoders return enc_ch* at T+2.
- sym_ch*, hsync, vsync, de are registered at T+3. Sync and de are delayed internally to match.

Symbol selection, at the output register:
- de=1: sym_chN = enc_chN.
- Otherwise ch0 = token(C1=vsync level, C0=hsync level); ch1 = ch2 = token(00).
- Tokens: 00=10'b1101010100, 01=10'b0010101011, 10=10'b0101010100, 11=10'b1010101011.
- In IDLE, sync outputs sit at their inactive levels and de=0. The 3-stage output delay keeps flushing the last frame's values for 3 cycles after entering IDLE.

Reset values:
- Counters, warm_cnt, pix_req, pix_x, pix_y, de, link_up = 0.
- hsync = ~HS_POL; vsync = ~VS_POL.
- sym_ch0 = token({~VS_POL,~HS_POL}); sym_ch1 = sym_ch2 = token(00).
- State = IDLE.
- Reset mid-frame returns to these values asynchronously with no frame completion.

Misc:
- link_up is registered and rises/falls on the same edge as the state change.
- Widths: counters are 12 bits; parameters must satisfy H_TOTAL, V_TOTAL ≤ 4096 (elaboration assertion).

Decomposition:
- Package tmds_pkg: four control-token constants, token-select function (2-bit C → 10-bit symbol), state enum {IDLE, WARMUP, ACTIVE}.
- Sub-module video_timing_gen: h/v counters, sync/display decode, FE pulse, run/clear input. Instantiated once.
- FSM, request pipeline and symbol mux stay in tmds_link_sequencer.

Test Plan (H=2/2/4/2, V=1/1/2/1, HS_POL=VS_POL=1, WARMUP_FRAMES=1, so H_TOTAL=10 and V_TOTAL=5):
- Reset with link_en=0 for 20 cycles -> sym_ch0=0x354 (token 00), sym_ch1=sym_ch2=0x354, hsync=vsync=de=link_up=0, pix_req never asserted.
- Assert link_en -> two full frames (100 cycles) with de=0; link_up rises at the second FE. ch0 shows 0x2AB during h_cnt<2 on line 0, and 0x0AB for hsync-only lines.
- ACTIVE with enc_ch0 = {pix_y[1:0],pix_x[1:0]} echoed one cycle after pix_req -> pix_x 0..3 per line, pix_y 0..1; sym_ch0 carries enc data exactly while de=1, 8 de cycles per frame.
- Drop link_en at mid-frame of ACTIVE -> frame completes with all 8 de cycles, link_up falls at FE, outputs return to idle tokens 3 cycles later.
- Drop link_en during WARMUP, then re-raise after 3 cycles -> IDLE immediately, warm_cnt reloaded, a full warm-up frame precedes video.
- Assert rst_n=0 mid-line in ACTIVE -> all outputs go to reset values without a clock edge; after release, idle until link_en is seen.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS control tokens, token selector and link-state encoding.
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        ACTIVE
    } link_state_e;

    // c = {C1, C0} = {vsync level, hsync level}
    function automatic logic [9:0] tmds_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOK_00;
            2'b01:   t = TOK_01;
            2'b10:   t = TOK_10;
            default: t = TOK_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with sync, display and frame-end decode.
module video_timing_gen #(
    parameter int H_SYNC  = 44,
    parameter int H_BACK  = 148,
    parameter int H_DISP  = 1920,
    parameter int H_FRONT = 88,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 36,
    parameter int V_DISP  = 1080,
    parameter int V_FRONT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    output logic [11:0] h_cnt_o,
    output logic [11:0] v_cnt_o,
    output logic        hs_act_o,
    output logic        vs_act_o,
    output logic        disp_o,
    output logic        fe_o
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_DS    = H_SYNC + H_BACK;
    localparam int H_DE    = H_DS + H_DISP;
    localparam int V_DS    = V_SYNC + V_BACK;
    localparam int V_DE    = V_DS + V_DISP;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_totals
        $error("video_timing_gen: totals exceed 12-bit counter range");
    end

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic        h_wrap;
    logic        v_wrap;

    assign h_wrap = (h_q == 12'(H_TOTAL - 1));
    assign v_wrap = (v_q == 12'(V_TOTAL - 1));

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? 12'd0 : v_q + 12'd1;
        end else begin
            h_d = h_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o  = h_q;
    assign v_cnt_o  = v_q;
    assign hs_act_o = int'(h_q) < H_SYNC;
    assign vs_act_o = int'(v_q) < V_SYNC;
    assign disp_o   = (int'(h_q) >= H_DS) && (int'(h_q) < H_DE)
                   && (int'(v_q) >= V_DS) && (int'(v_q) < V_DE);
    assign fe_o     = h_wrap && v_wrap;

endmodule

// File: rtl/tmds_link_sequencer.sv
// TMDS link start-up sequencer: warm-up control frames, pixel requests
// and per-channel symbol selection for the 10:1 serializers.
module tmds_link_sequencer
    import tmds_pkg::*;
#(
    parameter int H_SYNC        = 44,
    parameter int H_BACK        = 148,
    parameter int H_DISP        = 1920,
    parameter int H_FRONT       = 88,
    parameter int V_SYNC        = 5,
    parameter int V_BACK        = 36,
    parameter int V_DISP        = 1080,
    parameter int V_FRONT       = 4,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        link_en,
    input  logic [9:0]  enc_ch0,
    input  logic [9:0]  enc_ch1,
    input  logic [9:0]  enc_ch2,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [9:0]  sym_ch0,
    output logic [9:0]  sym_ch1,
    output logic [9:0]  sym_ch2,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        link_up
);

    localparam int H_DS = H_SYNC + H_BACK;
    localparam int V_DS = V_SYNC + V_BACK;

    link_state_e state_q, state_d;
    logic [3:0]  warm_q, warm_d;
    logic        link_up_q;
    logic        run;
    logic [11:0] h_cnt, v_cnt;
    logic        hs_act, vs_act, disp, fe;
    logic        on, act;

    logic        req_q;
    logic [11:0] x_q, y_q;
    logic        hs1_q, vs1_q;
    logic        hs2_q, vs2_q, de2_q;
    logic        hs_lvl, vs_lvl;
    logic        hsync_q, vsync_q, de_q;
    logic [9:0]  sym0_q, sym1_q, sym2_q;
    logic [9:0]  sym0_d, sym1_d, sym2_d;

    // Counters must also read 0 on the first WARMUP cycle, so hold
    // them while either side of the transition is IDLE.
    assign run = (state_q != IDLE) && (state_d != IDLE);

    video_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BACK (H_BACK),
        .H_DISP (H_DISP),
        .H_FRONT(H_FRONT),
        .V_SYNC (V_SYNC),
        .V_BACK (V_BACK),
        .V_DISP (V_DISP),
        .V_FRONT(V_FRONT)
    ) u_timing (
        .clk_i   (pixel_clk),
        .rst_ni  (rst_n),
        .run_i   (run),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .hs_act_o(hs_act),
        .vs_act_o(vs_act),
        .disp_o  (disp),
        .fe_o    (fe)
    );

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        unique case (state_q)
            IDLE: begin
                if (link_en) begin
                    state_d = WARMUP;
                    warm_d  = 4'(WARMUP_FRAMES);
                end
            end
            WARMUP: begin
                if (!link_en) begin
                    state_d = IDLE;
                end else if (fe) begin
                    if (warm_q == 4'd0) state_d = ACTIVE;
                    else                warm_d  = warm_q - 4'd1;
                end
            end
            ACTIVE: begin
                if (fe && !link_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            warm_q    <= '0;
            link_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            link_up_q <= (state_d == ACTIVE);
        end
    end

    assign on  = (state_q != IDLE);
    assign act = (state_q == ACTIVE);

    // Sync and de ride two stages alongside the request so they meet
    // the encoder data at the output register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            de2_q <= 1'b0;
        end else begin
            req_q <= disp && act;
            x_q   <= h_cnt - 12'(H_DS);
            y_q   <= v_cnt - 12'(V_DS);
            hs1_q <= hs_act && on;
            vs1_q <= vs_act && on;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= req_q;
        end
    end

    assign hs_lvl = hs2_q ? HS_POL : ~HS_POL;
    assign vs_lvl = vs2_q ? VS_POL : ~VS_POL;

    always_comb begin
        sym0_d = tmds_token({vs_lvl, hs_lvl});
        sym1_d = TOK_00;
        sym2_d = TOK_00;
        if (de2_q) begin
            sym0_d = enc_ch0;
            sym1_d = enc_ch1;
            sym2_d = enc_ch2;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            sym0_q  <= tmds_token({~VS_POL, ~HS_POL});
            sym1_q  <= TOK_00;
            sym2_q  <= TOK_00;
        end else begin
            hsync_q <= hs_lvl;
            vsync_q <= vs_lvl;
            de_q    <= de2_q;
            sym0_q  <= sym0_d;
            sym1_q  <= sym1_d;
            sym2_q  <= sym2_d;
        end
    end

    assign pix_req = req_q;
    assign pix_x   = x_q;
    assign pix_y   = y_q;
    assign sym_ch0 = sym0_q;
    assign sym_ch1 = sym1_q;
    assign sym_ch2 = sym2_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign link_up = link_up_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench for tmds_link_sequencer on a 10x5 raster with a
// reference raster/FSM model feeding a 3-deep output scoreboard.
module tb_tmds_link_sequencer;

    localparam int HT  = 10;
    localparam int VT  = 5;
    localparam int WF  = 1;
    localparam int WLEN = 1 + (WF + 1) * HT * VT;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic        link_en;
    logic [9:0]  enc_ch0, enc_ch1, enc_ch2;
    logic        pix_req;
    logic [11:0] pix_x, pix_y;
    logic [9:0]  sym_ch0, sym_ch1, sym_ch2;
    logic        hsync, vsync, de, link_up;

    always #5 pixel_clk = ~pixel_clk;

    tmds_link_sequencer #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .WARMUP_FRAMES(WF)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n    (rst_n),
        .link_en  (link_en),
        .enc_ch0  (enc_ch0),
        .enc_ch1  (enc_ch1),
        .enc_ch2  (enc_ch2),
        .pix_req  (pix_req),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .sym_ch0  (sym_ch0),
        .sym_ch1  (sym_ch1),
        .sym_ch2  (sym_ch2),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .link_up  (link_up)
    );

    typedef struct {
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        de;
    } rec_t;

    rec_t        sb[$];
    int          ncmp = 0;
    int          nfail = 0;
    int          m_state, m_warm, m_h, m_v;
    logic [11:0] pv_x, pv_y;
    int          de_cnt;
    int          n;

    function automatic logic [9:0] tok(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'd0:    t = 10'h354;
            2'd1:    t = 10'h0AB;
            2'd2:    t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    function automatic logic [9:0] e0(input logic [11:0] x, input logic [11:0] y);
        return {6'd0, y[1:0], x[1:0]};
    endfunction

    function automatic logic [9:0] e1(input logic [11:0] x, input logic [11:0] y);
        return {x[1:0], y[1:0], 6'h15};
    endfunction

    function automatic logic [9:0] e2(input logic [11:0] x, input logic [11:0] y);
        return 10'h3FF ^ e0(x, y);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t idle;
        idle = '{req: 1'b0, x: 12'd0, y: 12'd0, hs: 1'b0, vs: 1'b0, de: 1'b0};
        m_state = 0;
        m_warm  = 0;
        m_h     = 0;
        m_v     = 0;
        sb.delete();
        sb.push_back(idle);
        sb.push_back(idle);
    endtask

    task automatic chk_reset_vals();
        chk("rst_sym0", sym_ch0, 10'h354);
        chk("rst_sym1", sym_ch1, 10'h354);
        chk("rst_sym2", sym_ch2, 10'h354);
        chk("rst_hsync", hsync, 1'b0);
        chk("rst_vsync", vsync, 1'b0);
        chk("rst_de", de, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_pix_req", pix_req, 1'b0);
        chk("rst_pix_x", pix_x, 12'd0);
        chk("rst_pix_y", pix_y, 12'd0);
    endtask

    task automatic tick();
        rec_t r, e;
        int   ns, nw, nh, nv;
        logic fe, disp;
        disp  = (m_h >= 4) && (m_h < 8) && (m_v >= 2) && (m_v < 4);
        r.req = disp && (m_state == 2);
        r.de  = r.req;
        r.x   = 12'(m_h - 4);
        r.y   = 12'(m_v - 2);
        r.hs  = (m_state != 0) && (m_h < 2);
        r.vs  = (m_state != 0) && (m_v < 1);
        fe    = (m_h == HT - 1) && (m_v == VT - 1);
        ns = m_state;
        nw = m_warm;
        case (m_state)
            0: if (link_en) begin ns = 1; nw = WF; end
            1: begin
                if (!link_en) ns = 0;
                else if (fe) begin
                    if (m_warm == 0) ns = 2;
                    else nw = m_warm - 1;
                end
            end
            default: if (fe && !link_en) ns = 0;
        endcase
        if (m_state == 0 || ns == 0) begin
            nh = 0;
            nv = 0;
        end else begin
            nh = (m_h + 1) % HT;
            nv = (m_h == HT - 1) ? (m_v + 1) % VT : m_v;
        end
        sb.push_back(r);
        @(posedge pixel_clk);
        #1;
        m_state = ns;
        m_warm  = nw;
        m_h     = nh;
        m_v     = nv;
        enc_ch0 = e0(pv_x, pv_y);
        enc_ch1 = e1(pv_x, pv_y);
        enc_ch2 = e2(pv_x, pv_y);
        pv_x = pix_x;
        pv_y = pix_y;
        chk("pix_req", pix_req, r.req);
        if (r.req) begin
            chk("pix_x", pix_x, r.x);
            chk("pix_y", pix_y, r.y);
        end
        chk("link_up", link_up, m_state == 2);
        e = sb.pop_front();
        chk("hsync", hsync, e.hs);
        chk("vsync", vsync, e.vs);
        chk("de", de, e.de);
        chk("sym_ch0", sym_ch0, e.de ? e0(e.x, e.y) : tok({e.vs, e.hs}));
        chk("sym_ch1", sym_ch1, e.de ? e1(e.x, e.y) : 10'h354);
        chk("sym_ch2", sym_ch2, e.de ? e2(e.x, e.y) : 10'h354);
        if (de === 1'b1) de_cnt++;
    endtask

    initial begin
        rst_n   = 1'b0;
        link_en = 1'b0;
        enc_ch0 = '0;
        enc_ch1 = '0;
        enc_ch2 = '0;
        pv_x    = '0;
        pv_y    = '0;
        de_cnt  = 0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_reset_vals();
        @(negedge pixel_clk);
        rst_n = 1'b1;
        model_reset();

        repeat (20) tick();

        link_en = 1'b1;
        n = 0;
        while (m_state != 2 && n < 300) begin
            tick();
            n++;
        end
        chk("warmup_len", 12'(n), 12'(WLEN));

        de_cnt = 0;
        repeat (HT * VT) tick();
        chk("de_per_frame", 12'(de_cnt), 12'd8);

        de_cnt = 0;
        n = 0;
        while (!(m_v == 2 && m_h == 6) && n < 100) begin
            tick();
            n++;
        end
        link_en = 1'b0;
        n = 0;
        while (m_state != 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("de_last_frame", 12'(de_cnt), 12'd8);

        link_en = 1'b1;
        repeat (30) tick();
        link_en = 1'b0;
        repeat (3) tick();
        link_en = 1'b1;
        n = 0;
        while (link_up !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("rewarm_len", 12'(n), 12'(WLEN));

        repeat (60) tick();
        n = 0;
        while (!(m_state == 2 && m_v == 2 && m_h == 7) && n < 100) begin
            tick();
            n++;
        end
        @(negedge pixel_clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        link_en = 1'b0;
        rst_n   = 1'b1;
        model_reset();
        repeat (10) tick();
        link_en = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
